// File: rtl/ads1115_i2c_responder_pkg.sv
// Shared definitions for the ADS1115 I2C target: register pointers, reset values and FSM encodings.
// The master side imports the same package so both ends agree on state and pointer codes.
package ads1115_i2c_responder_pkg;

   localparam logic [1:0] PTR_CONV = 2'd0;
   localparam logic [1:0] PTR_CFG  = 2'd1;
   localparam logic [1:0] PTR_LO   = 2'd2;
   localparam logic [1:0] PTR_HI   = 2'd3;

   localparam logic [6:0]  ADS_DEV_ADDR = 7'h48;
   localparam logic [15:0] ADS_CFG_RST  = 16'h8583;
   localparam logic [15:0] ADS_LO_RST   = 16'h8000;
   localparam logic [15:0] ADS_HI_RST   = 16'h7FFF;

   typedef enum logic [3:0] {
      ST_IDLE, ST_ADDR, ST_ACK_ADDR, ST_PTR, ST_ACK_PTR, ST_WR_MSB, ST_ACK_MSB,
      ST_WR_LSB, ST_ACK_LSB, ST_RD_MSB, ST_MACK_MSB, ST_RD_LSB, ST_MACK_LSB, ST_NOMATCH
   } state_t;

   // Shadow bit index driven after `cnt` bits of the current read byte have been clocked out.
   function automatic logic [3:0] tx_bit_idx(input logic lsb_byte, input logic [2:0] cnt);
      return {~lsb_byte, ~cnt};
   endfunction

endpackage

// File: rtl/ads1115_i2c_responder_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus edge and START/STOP condition pulses.
// Pulses are combinational from synchronized copies, so the FSM acts three clocks after the pin moves.
module ads1115_i2c_responder_bus_sync (
   input  logic clk,
   input  logic rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic scl_p0, scl_p1, scl_p2;
   logic sda_p0, sda_p1, sda_p2;

   // Idle bus reads high, so reset to 1 to avoid a phantom edge after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_p0 <= 1'b1;
         scl_p1 <= 1'b1;
         scl_p2 <= 1'b1;
         sda_p0 <= 1'b1;
         sda_p1 <= 1'b1;
         sda_p2 <= 1'b1;
      end else begin
         scl_p0 <= scl_in;
         scl_p1 <= scl_p0;
         scl_p2 <= scl_p1;
         sda_p0 <= sda_in;
         sda_p1 <= sda_p0;
         sda_p2 <= sda_p1;
      end
   end

   assign sda_s    = sda_p1;
   assign scl_rise = scl_p1 & ~scl_p2;
   assign scl_fall = ~scl_p1 & scl_p2;
   assign start    = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
   assign stop     = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

endmodule

// File: rtl/ads1115_i2c_responder.sv
// I2C target emulating the ADS1115 register file: address/pointer decode, 16-bit writes,
// snapshot-based 16-bit reads, open-drain SDA via sda_oe that only changes while SCL is low.
module ads1115_i2c_responder
   import ads1115_i2c_responder_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR = ADS_DEV_ADDR,
   parameter logic [15:0] CFG_RST  = ADS_CFG_RST,
   parameter logic [15:0] LO_RST   = ADS_LO_RST,
   parameter logic [15:0] HI_RST   = ADS_HI_RST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [15:0] conv_data,
   input  logic        conv_load,
   output logic [15:0] config_reg,
   output logic [1:0]  pointer,
   output logic        wr_strobe,
   output logic        busy
);

   logic        sda, scl_rise, scl_fall, start, stop;
   state_t      state;
   logic [6:0]  shreg;
   logic [2:0]  bit_cnt;
   logic        rw, ack_rise;
   logic [7:0]  msb_byte, lsb_byte;
   logic [15:0] conv_reg, lo_reg, hi_reg, shadow, reg_rd;
   logic [7:0]  rx_byte;

   ads1115_i2c_responder_bus_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .scl_in   (scl_in),
      .sda_in   (sda_in),
      .sda_s    (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   assign rx_byte = {shreg, sda};

   always_comb begin
      reg_rd = conv_reg;
      case (pointer)
         PTR_CFG: reg_rd = config_reg;
         PTR_LO:  reg_rd = lo_reg;
         PTR_HI:  reg_rd = hi_reg;
         default: reg_rd = conv_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         sda_oe     <= 1'b0;
         pointer    <= PTR_CONV;
         conv_reg   <= '0;
         config_reg <= CFG_RST;
         lo_reg     <= LO_RST;
         hi_reg     <= HI_RST;
         wr_strobe  <= 1'b0;
         busy       <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         rw         <= 1'b0;
         ack_rise   <= 1'b0;
         msb_byte   <= '0;
         lsb_byte   <= '0;
         shadow     <= '0;
      end else begin
         wr_strobe <= 1'b0;
         // Conversion updates never touch the shadow, so an in-flight read stays coherent.
         if (conv_load)
            conv_reg <= conv_data;

         if (start) begin
            state    <= ST_ADDR;
            bit_cnt  <= '0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            ack_rise <= 1'b0;
         end else if (stop) begin
            state    <= ST_IDLE;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            ack_rise <= 1'b0;
         end else begin
            case (state)
               ST_ADDR, ST_PTR, ST_WR_MSB, ST_WR_LSB: begin
                  if (scl_rise) begin
                     shreg   <= rx_byte[6:0];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        ack_rise <= 1'b0;
                        case (state)
                           ST_ADDR: begin
                              if (rx_byte[7:1] == DEV_ADDR) begin
                                 rw    <= rx_byte[0];
                                 busy  <= 1'b1;
                                 state <= ST_ACK_ADDR;
                              end else begin
                                 state <= ST_NOMATCH;
                              end
                           end
                           ST_PTR: begin
                              pointer <= rx_byte[1:0];
                              state   <= ST_ACK_PTR;
                           end
                           ST_WR_MSB: begin
                              msb_byte <= rx_byte;
                              state    <= ST_ACK_MSB;
                           end
                           default: begin
                              lsb_byte <= rx_byte;
                              state    <= ST_ACK_LSB;
                           end
                        endcase
                     end
                  end
               end

               // First SCL fall starts the ACK pulse; the fall after the 9th rise ends it.
               ST_ACK_ADDR, ST_ACK_PTR, ST_ACK_MSB, ST_ACK_LSB: begin
                  if (scl_rise) begin
                     ack_rise <= 1'b1;
                  end else if (scl_fall) begin
                     if (!ack_rise) begin
                        sda_oe <= 1'b1;
                     end else begin
                        sda_oe   <= 1'b0;
                        ack_rise <= 1'b0;
                        bit_cnt  <= '0;
                        case (state)
                           ST_ACK_ADDR: begin
                              if (rw) begin
                                 shadow <= reg_rd;
                                 sda_oe <= ~reg_rd[15];
                                 state  <= ST_RD_MSB;
                              end else begin
                                 state <= ST_PTR;
                              end
                           end
                           ST_ACK_PTR: state <= ST_WR_MSB;
                           ST_ACK_MSB: state <= ST_WR_LSB;
                           default: begin
                              case (pointer)
                                 PTR_CFG: config_reg <= {msb_byte, lsb_byte};
                                 PTR_LO:  lo_reg     <= {msb_byte, lsb_byte};
                                 PTR_HI:  hi_reg     <= {msb_byte, lsb_byte};
                                 default: ;
                              endcase
                              wr_strobe <= 1'b1;
                              state     <= ST_WR_MSB;
                           end
                        endcase
                     end
                  end
               end

               ST_RD_MSB, ST_RD_LSB: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        ack_rise <= 1'b0;
                        state    <= (state == ST_RD_MSB) ? ST_MACK_MSB : ST_MACK_LSB;
                     end
                  end else if (scl_fall) begin
                     sda_oe <= ~shadow[tx_bit_idx(state == ST_RD_LSB, bit_cnt)];
                  end
               end

               ST_MACK_MSB, ST_MACK_LSB: begin
                  if (scl_rise) begin
                     if (!sda)
                        ack_rise <= 1'b1;
                     else
                        state <= ST_NOMATCH;
                  end else if (scl_fall) begin
                     if (!ack_rise) begin
                        sda_oe <= 1'b0;
                     end else begin
                        ack_rise <= 1'b0;
                        bit_cnt  <= '0;
                        if (state == ST_MACK_MSB) begin
                           sda_oe <= ~shadow[7];
                           state  <= ST_RD_LSB;
                        end else begin
                           shadow <= reg_rd;
                           sda_oe <= ~reg_rd[15];
                           state  <= ST_RD_MSB;
                        end
                     end
                  end
               end

               default: sda_oe <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ads1115_i2c_responder.sv
// Directed bench: bit-banged I2C master against the ADS1115 responder with hand-computed expectations.
module tb_ads1115_i2c_responder;
   localparam int H = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scl = 1'b1;
   logic        m_sda_low = 1'b0;
   logic        sda_pin;
   logic        sda_oe;
   logic [15:0] conv_data = '0;
   logic        conv_load = 1'b0;
   logic [15:0] config_reg;
   logic [1:0]  pointer;
   logic        wr_strobe;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;
   int strobe_cnt = 0;

   assign sda_pin = ~(sda_oe | m_sda_low);

   ads1115_i2c_responder dut (
      .clk        (clk),
      .rst        (rst),
      .scl_in     (scl),
      .sda_in     (sda_pin),
      .sda_oe     (sda_oe),
      .conv_data  (conv_data),
      .conv_load  (conv_load),
      .config_reg (config_reg),
      .pointer    (pointer),
      .wr_strobe  (wr_strobe),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (wr_strobe) strobe_cnt <= strobe_cnt + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda_low = 1'b0;
      wait_clk(H);
      scl = 1'b1;
      wait_clk(H);
      m_sda_low = 1'b1;
      wait_clk(H);
      scl = 1'b0;
      wait_clk(2);
   endtask

   task automatic i2c_stop();
      m_sda_low = 1'b1;
      wait_clk(H);
      scl = 1'b1;
      wait_clk(H);
      m_sda_low = 1'b0;
      wait_clk(H);
   endtask

   task automatic write_bit(input logic b);
      m_sda_low = ~b;
      wait_clk(H);
      scl = 1'b1;
      wait_clk(H);
      scl = 1'b0;
      wait_clk(2);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack_bit);
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      m_sda_low = 1'b0;
      wait_clk(H);
      scl = 1'b1;
      wait_clk(H);
      ack_bit = sda_pin;
      scl = 1'b0;
      wait_clk(2);
   endtask

   task automatic read_byte(input logic m_ack, output logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         m_sda_low = 1'b0;
         wait_clk(H);
         scl = 1'b1;
         wait_clk(H);
         b[i] = sda_pin;
         scl = 1'b0;
         wait_clk(2);
      end
      m_sda_low = m_ack;
      wait_clk(H);
      scl = 1'b1;
      wait_clk(H);
      scl = 1'b0;
      wait_clk(2);
      m_sda_low = 1'b0;
   endtask

   task automatic load_conv(input logic [15:0] v);
      conv_data = v;
      conv_load = 1'b1;
      wait_clk(1);
      conv_load = 1'b0;
   endtask

   initial begin
      logic       a;
      logic [7:0] rb;
      int         s0;

      wait_clk(5);
      rst = 1'b0;
      wait_clk(1);
      chk("rst_sda_oe", 32'(sda_oe), 32'h0);
      chk("rst_config", 32'(config_reg), 32'h8583);
      chk("rst_pointer", 32'(pointer), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);

      // config write
      s0 = strobe_cnt;
      i2c_start();
      write_byte(8'h90, a); chk("wr_ack_addr", 32'(a), 32'h0);
      write_byte(8'h01, a); chk("wr_ack_ptr", 32'(a), 32'h0);
      write_byte(8'hC3, a); chk("wr_ack_msb", 32'(a), 32'h0);
      write_byte(8'h83, a); chk("wr_ack_lsb", 32'(a), 32'h0);
      i2c_stop();
      chk("wr_config", 32'(config_reg), 32'hC383);
      chk("wr_strobes", 32'(strobe_cnt - s0), 32'h1);
      chk("wr_pointer", 32'(pointer), 32'h1);
      chk("wr_busy_after_stop", 32'(busy), 32'h0);

      // conversion read through repeated start
      load_conv(16'h1A2B);
      i2c_start();
      write_byte(8'h90, a); chk("rd_ack_addr_w", 32'(a), 32'h0);
      chk("rd_busy", 32'(busy), 32'h1);
      write_byte(8'h00, a); chk("rd_ack_ptr", 32'(a), 32'h0);
      chk("rd_pointer", 32'(pointer), 32'h0);
      i2c_start();
      write_byte(8'h91, a); chk("rd_ack_addr_r", 32'(a), 32'h0);
      read_byte(1'b1, rb); chk("rd_msb", 32'(rb), 32'h1A);
      read_byte(1'b0, rb); chk("rd_lsb", 32'(rb), 32'h2B);
      wait_clk(H);
      chk("rd_released", 32'(sda_oe), 32'h0);
      i2c_stop();

      // foreign address
      i2c_start();
      write_byte(8'h92, a); chk("nm_nack", 32'(a), 32'h1);
      chk("nm_busy", 32'(busy), 32'h0);
      i2c_stop();
      chk("nm_config", 32'(config_reg), 32'hC383);

      // conv_load between MSB and LSB must not tear the read
      i2c_start();
      write_byte(8'h91, a); chk("tr_ack_addr", 32'(a), 32'h0);
      read_byte(1'b1, rb); chk("tr_msb", 32'(rb), 32'h1A);
      load_conv(16'hFFFF);
      read_byte(1'b0, rb); chk("tr_lsb", 32'(rb), 32'h2B);
      i2c_stop();
      i2c_start();
      write_byte(8'h91, a);
      read_byte(1'b1, rb); chk("tr2_msb", 32'(rb), 32'hFF);
      read_byte(1'b1, rb); chk("tr2_lsb", 32'(rb), 32'hFF);
      read_byte(1'b0, rb); chk("tr2_msb_again", 32'(rb), 32'hFF);
      i2c_stop();

      // STOP inside the pointer byte leaves the pointer alone
      i2c_start();
      write_byte(8'h90, a);
      write_byte(8'h02, a);
      i2c_stop();
      chk("ab_pointer_set", 32'(pointer), 32'h2);
      i2c_start();
      write_byte(8'h90, a);
      for (int i = 0; i < 4; i++) write_bit(1'b0);
      i2c_stop();
      chk("ab_pointer_kept", 32'(pointer), 32'h2);
      chk("ab_busy", 32'(busy), 32'h0);
      i2c_start();
      write_byte(8'h91, a);
      read_byte(1'b1, rb); chk("ab_lo_msb", 32'(rb), 32'h80);
      read_byte(1'b0, rb); chk("ab_lo_lsb", 32'(rb), 32'h00);
      i2c_stop();

      // reset while the address ACK is being driven
      i2c_start();
      for (int i = 7; i >= 0; i--) write_bit(1'(8'h90 >> i));
      m_sda_low = 1'b0;
      wait_clk(H);
      chk("ra_ack_driven", 32'(sda_oe), 32'h1);
      rst = 1'b1;
      wait_clk(1);
      chk("ra_sda_released", 32'(sda_oe), 32'h0);
      chk("ra_config", 32'(config_reg), 32'h8583);
      chk("ra_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      scl = 1'b1;
      wait_clk(H);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
